keys_event_queue: RTL and testbench
===================================

// Module: keys_event_queue
// PURPOSE
//  Consumer end of the keys_debounce press interface. Takes the per-key one-cycle
//  press pulses (btn_ondn), encodes each press as a key index and queues it in a
//  small FIFO. A downstream FSM reads the queue through a valid/ready handshake.
//  No press is lost while the queue has room. Simultaneous presses are serialised
//  lowest index first. Sits between keys_debounce and the lab control logic.
// PARAMETERS
//  N_KEYS  5  number of key pulse inputs (1..8)
//  CODE_W  3  width of key index code; 2**CODE_W >= N_KEYS
//  DEPTH   8  FIFO entries; power of two, >= 2
//  PTR_W   3  log2(DEPTH)
// PORTS
//  clk_i       in   1         system clock (50 MHz)
//  rst_i       in   1         synchronous reset, active-high
//  ondn_i      in   N_KEYS    press pulses, bit k = key k pressed (1 clk wide each)
//  code_o      out  CODE_W    key index at FIFO head; valid only when valid_o=1
//  valid_o     out  1         FIFO not empty
//  ready_i     in   1         consumer accepts head this cycle
//  count_o     out  PTR_W+1   number of entries stored (0..DEPTH)
//  overflow_o  out  1         sticky: at least one press was dropped
// BEHAVIOUR
//  Reset (rst_i=1 at posedge): pend=0, wr/rd ptr=0, count_o=0, valid_o=0,
//   code_o=0, overflow_o=0. Reset overrides all other activity in that cycle.
//  Pending register pend[N_KEYS-1:0]:
//   - grant = lowest set bit of pend (one-hot, 0 if pend==0)
//   - wr_en = (pend!=0) && (count<DEPTH || pop)
//   - pend_next = (pend & ~(wr_en ? grant : 0)) | ondn_i
//   - collision: ondn_i[k]=1 while pend[k]=1 and bit k not granted this cycle
//     -> press merged (dropped), overflow_o<=1. Only the pend bit makes entries.
//  Write: on wr_en, mem[wr_ptr] <= index(grant), wr_ptr++ (wraps mod DEPTH).
//   At most one write per cycle.
//  Read (first-word-fall-through): code_o = mem[rd_ptr]; valid_o = (count!=0).
//   pop = valid_o && ready_i; on pop rd_ptr++ (wraps). ready_i ignored when empty.
//  count: +1 on write only, -1 on pop only, unchanged on both or neither.
//   Full with pop and write in the same cycle is legal; count stays DEPTH.
//   Write when empty plus ready_i in the same cycle: no pop. The new entry is
//   visible next cycle.
//  Latency: pulse on ondn_i in cycle t -> pend set at end of t -> written at end
//   of t+1 -> valid_o=1 and code_o=k in cycle t+2 (if queue was empty).
//  Full (count=DEPTH, no pop): pend holds its bits. No loss until a collision.
//  overflow_o clears only on rst_i.
//  Reset mid-operation discards all queued and pending presses.
//  Outputs registered: code_o comes from the mem read at rd_ptr; valid_o and
//   count_o come from registered count. No combinational path ready_i->valid_o.
// TESTING
//  1 rst_i=1 for 2 clk -> valid_o=0, count_o=0, overflow_o=0, code_o=0.
//  2 ondn_i=5'b00100 in cycle 0, ready_i=0 -> valid_o=1, code_o=2 from cycle 2,
//    count_o=1. Then ready_i=1 for 1 clk -> count_o=0, valid_o=0.
//  3 ondn_i=5'b10011 in one cycle, ready_i=0 -> codes 0,1,4 enqueued on
//    consecutive cycles, count_o=3. Drain reads 0,1,4 in that order.
//  4 ready_i=0, key1 pulsed 9 times 3 clk apart -> count_o=8, 9th press held,
//    overflow_o=0. 10th key1 pulse -> overflow_o=1. Drain -> nine codes of 1.
//  5 queue full, ready_i=1 and pend!=0 in the same cycle -> count_o stays 8,
//    popped code correct, new code appears after 7 further pops.
//  6 count_o=5 and pend=5'b01000, rst_i=1 for 1 clk -> count_o=0, valid_o=0, no
//    code 3 appears afterwards, overflow_o=0.

Source files
------------

// File: rtl/keys_event_queue.sv
// keys_event_queue
//   Consumer end of the keys_debounce press interface. One-cycle press pulses
//   are latched into a pending register, serialised lowest key index first,
//   and written one per cycle into a small first-word-fall-through FIFO that a
//   downstream FSM drains through a valid/ready handshake.
//
// Ports
//   clk_i       system clock
//   rst_i       synchronous reset, active-high; clears queue, pending presses
//               and the overflow flag
//   ondn_i      press pulses, bit k = key k pressed (one clock wide)
//   code_o      key index at the FIFO head, meaningful only while valid_o=1
//   valid_o     FIFO not empty
//   ready_i     consumer takes the head entry this cycle (ignored when empty)
//   count_o     number of stored entries, 0..DEPTH
//   overflow_o  sticky, set when a press was merged into an already pending
//               press of the same key and therefore lost
module keys_event_queue #(
    parameter int N_KEYS = 5,
    parameter int CODE_W = 3,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N_KEYS-1:0] ondn_i,
    output logic [CODE_W-1:0] code_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [PTR_W:0]    count_o,
    output logic              overflow_o
);

    logic [CODE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              overflow;

    logic [N_KEYS-1:0] pend;
    logic [N_KEYS-1:0] grant;
    logic [N_KEYS-1:0] clr_mask;
    logic [N_KEYS-1:0] pend_next;
    logic [CODE_W-1:0] grant_idx;
    logic              pend_any;
    logic              full;
    logic              pop;
    logic              wr_en;
    logic              collision;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [CODE_W-1:0] lowest_index(input logic [N_KEYS-1:0] v);
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int k = N_KEYS - 1; k >= 0; k--) begin
            if (v[k]) idx = CODE_W'(k);
        end
        return idx;
    endfunction

    always_comb begin
        pend_any  = |pend;
        grant_idx = lowest_index(pend);
        grant     = pend_any ? (N_KEYS'(1) << grant_idx) : '0;
        full      = (count == (PTR_W + 1)'(DEPTH));
        pop       = (count != '0) && ready_i;
        // A pop frees a slot in the same cycle, so a full queue still accepts
        // a write when the head is being taken.
        wr_en     = pend_any && (!full || pop);
        clr_mask  = wr_en ? grant : '0;
        pend_next = (pend & ~clr_mask) | ondn_i;
        // A new pulse on a key whose earlier press is still pending (and not
        // leaving the pending register this cycle) merges into it: one press lost.
        collision = |(ondn_i & pend & ~clr_mask);
    end

    // Control state: pending presses, pointers, occupancy, sticky overflow
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            pend <= pend_next;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (collision) overflow <= 1'b1;
        end
    end

    // Storage: no reset needed, pointers define which entries are live
    always_ff @(posedge clk_i) begin
        if (wr_en && !rst_i) mem[wr_ptr] <= grant_idx;
    end

    // Outputs: all derived from registered state, no ready_i -> valid_o path
    assign valid_o    = (count != '0);
    assign code_o     = valid_o ? mem[rd_ptr] : '0;
    assign count_o    = count;
    assign overflow_o = overflow;

endmodule

// File: tb/tb_keys_event_queue.sv
module tb_keys_event_queue;

    localparam int N_KEYS = 5;
    localparam int CODE_W = 3;
    localparam int DEPTH  = 8;
    localparam int PTR_W  = 3;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [N_KEYS-1:0] ondn_i;
    logic [CODE_W-1:0] code_o;
    logic              valid_o;
    logic              ready_i;
    logic [PTR_W:0]    count_o;
    logic              overflow_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [CODE_W-1:0] exp_q[$];

    keys_event_queue #(
        .N_KEYS(N_KEYS), .CODE_W(CODE_W), .DEPTH(DEPTH), .PTR_W(PTR_W)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .ondn_i     (ondn_i),
        .code_o     (code_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .count_o    (count_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse(input logic [N_KEYS-1:0] mask);
        ondn_i = mask;
        tick();
        ondn_i = '0;
    endtask

    // Drain the queue with ready held high; the monitor checks each popped code.
    task automatic drain(input string name, input int limit);
        int guard;
        guard = 0;
        ready_i = 1'b1;
        while (valid_o && guard < limit) begin
            tick();
            guard++;
        end
        ready_i = 1'b0;
        chk({name, "_drain_timeout"}, (guard >= limit), 0);
        chk({name, "_drain_count"}, count_o, 0);
        chk({name, "_drain_left"}, exp_q.size(), 0);
    endtask

    // Monitor: a pop happens at the next posedge whenever valid && ready now.
    always @(negedge clk_i) begin
        if (rst_i === 1'b0 && valid_o === 1'b1 && ready_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pop_unexpected: got code %0d, expected no entry (t=%0t)", code_o, $time);
            end else begin
                logic [CODE_W-1:0] e;
                e = exp_q.pop_front();
                n_cmp++;
                if (code_o !== e) begin
                    n_bad++;
                    $display("FAIL pop_code: got %0d, expected %0d (t=%0t)", code_o, e, $time);
                end
            end
        end
    end

    initial begin
        rst_i   = 1'b1;
        ondn_i  = '0;
        ready_i = 1'b0;

        // 1: reset state
        tick();
        tick();
        rst_i = 1'b0;
        chk("rst_valid", valid_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_overflow", overflow_o, 0);
        chk("rst_code", code_o, 0);

        // 2: single press, latency two cycles, then one pop
        exp_q.push_back(3'd2);
        pulse(5'b00100);
        chk("t2_valid_c1", valid_o, 0);
        tick();
        chk("t2_valid_c2", valid_o, 1);
        chk("t2_code_c2", code_o, 2);
        chk("t2_count_c2", count_o, 1);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        chk("t2_count_after_pop", count_o, 0);
        chk("t2_valid_after_pop", valid_o, 0);

        // 3: simultaneous presses serialised lowest index first
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd4);
        pulse(5'b10011);
        chk("t3_count_c1", count_o, 0);
        tick();
        chk("t3_count_c2", count_o, 1);
        chk("t3_head_c2", code_o, 0);
        tick();
        tick();
        chk("t3_count", count_o, 3);
        drain("t3", 10);

        // 4: fill with key1, ninth held pending, tenth collides
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(3'd1);
            pulse(5'b00010);
            tick();
            tick();
        end
        chk("t4_count_full", count_o, 8);
        chk("t4_overflow_before", overflow_o, 0);
        pulse(5'b00010);
        chk("t4_overflow_after", overflow_o, 1);
        chk("t4_count_still_full", count_o, 8);
        drain("t4", 20);

        // 5: full queue, pop and write in the same cycle
        begin
            logic [N_KEYS-1:0] keys [9];
            keys = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000,
                     5'b00001, 5'b00010, 5'b00100, 5'b01000};
            for (int i = 0; i < 9; i++) begin
                exp_q.push_back(lowest_index_tb(keys[i]));
                pulse(keys[i]);
            end
        end
        chk("t5_count_full", count_o, 8);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        chk("t5_count_pop_write", count_o, 8);
        chk("t5_overflow_sticky", overflow_o, 1);
        chk("t5_head_after_pop", code_o, 1);
        drain("t5", 20);

        // 6: reset mid-operation discards queued and pending presses
        for (int k = 0; k < 5; k++) pulse(N_KEYS'(1) << k);
        pulse(5'b01000);
        chk("t6_count_before_rst", count_o, 5);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        exp_q.delete();
        chk("t6_count", count_o, 0);
        chk("t6_valid", valid_o, 0);
        chk("t6_overflow", overflow_o, 0);
        ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t6_valid_after", valid_o, 0);
        end
        ready_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    function automatic logic [CODE_W-1:0] lowest_index_tb(input logic [N_KEYS-1:0] v);
        for (int k = 0; k < N_KEYS; k++) if (v[k]) return CODE_W'(k);
        return '0;
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
